// File: rtl/grf_wb_arbiter_pkg.sv
// Shared writeback-pipeline definitions: arbiter FSM states and the zero register index.
package grf_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STARVE = 2'd2
  } arb_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         CNT_W    = 4;

endpackage

// File: rtl/grf_wb_arbiter_wb_scoreboard.sv
// Scoreboard of GRF registers with an MDU result still outstanding.
// Queries read registered state only; a same-cycle set beats a same-cycle clear.
module wb_scoreboard
  import grf_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       set_valid,
  input  logic [4:0] set_addr,
  input  logic       clr_valid,
  input  logic [4:0] clr_addr,
  input  logic [4:0] q_rs,
  input  logic [4:0] q_rt,
  output logic       q_hit
);

  logic [31:0] pending_reg;
  logic [31:0] pending_next;

  assign pending_next[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;
      assign set_hit = set_valid && (set_addr == 5'(gi));
      assign clr_hit = clr_valid && (clr_addr == 5'(gi));
      assign pending_next[gi] = set_hit | (pending_reg[gi] & ~clr_hit);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign q_hit = pending_reg[q_rs] | pending_reg[q_rt];

endmodule

// File: rtl/grf_wb_arbiter.sv
// Single GRF write port shared by the W stage (always wins) and the MDU valid/ready port,
// with a starvation watchdog that asks upstream for a W bubble when the MDU is blocked too long.
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_valid,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  input  logic [31:0] w_pc,
  input  logic        m_valid,
  input  logic [4:0]  m_addr,
  input  logic [31:0] m_data,
  input  logic [31:0] m_pc,
  output logic        m_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  input  logic [4:0]  q_rs,
  input  logic [4:0] q_rt,
  output logic        q_hit,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc,
  output logic        starve_stall
);

  logic w_eff;
  logic m_hs;
  logic m_blocked;

  assign w_eff     = w_valid && (w_addr != REG_ZERO);
  assign m_ready   = m_valid && !w_eff;
  assign m_hs      = m_valid && m_ready;
  assign m_blocked = m_valid && !m_ready;

  always_comb begin
    grf_we = 1'b0;
    grf_a3 = REG_ZERO;
    grf_wd = '0;
    grf_pc = '0;
    if (w_eff) begin
      grf_we = 1'b1;
      grf_a3 = w_addr;
      grf_wd = w_data;
      grf_pc = w_pc;
    end else if (m_valid) begin
      grf_we = (m_addr != REG_ZERO);
      grf_a3 = m_addr;
      grf_wd = m_data;
      grf_pc = m_pc;
    end
  end

  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_valid (iss_valid && (iss_addr != REG_ZERO)),
    .set_addr  (iss_addr),
    .clr_valid (m_hs),
    .clr_addr  (m_addr),
    .q_rs      (q_rs),
    .q_rt      (q_rt),
    .q_hit     (q_hit)
  );

  arb_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W:0]   cnt_plus1;

  assign cnt_plus1 = {1'b0, cnt_reg} + 5'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (m_blocked) begin
          cnt_next = 4'd1;
          // A limit of one means the first blocked cycle already exhausts the budget.
          state_next = (STARVE_LIMIT <= 1) ? STARVE : WAIT;
        end
      end
      WAIT: begin
        if (m_hs || !m_valid) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = (cnt_reg == 4'hF) ? cnt_reg : cnt_plus1[CNT_W-1:0];
          if (cnt_plus1 >= 5'(STARVE_LIMIT)) begin
            state_next = STARVE;
          end
        end
      end
      STARVE: begin
        if (m_hs || !m_valid) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign starve_stall = (state_reg == STARVE);

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Randomized and directed check of grf_wb_arbiter against a behavioural model.
module tb_grf_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_valid, m_valid, iss_valid;
  logic [4:0]  w_addr, m_addr, iss_addr, q_rs, q_rt;
  logic [31:0] w_data, w_pc, m_data, m_pc;
  logic        m_ready, q_hit, grf_we, starve_stall;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc;

  always #5 clk = ~clk;

  grf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .w_pc(w_pc),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_pc(m_pc), .m_ready(m_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .q_rs(q_rs), .q_rt(q_rt), .q_hit(q_hit),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
    .starve_stall(starve_stall)
  );

  // Model: set of outstanding registers, and length of the current run of blocked MDU cycles.
  bit model_pend [32];
  int blocked_run;
  int n_vec;
  int n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit wv, input logic [4:0] wa, input logic [31:0] wd,
                      input bit mv, input logic [4:0] ma, input logic [31:0] md,
                      input bit iv, input logic [4:0] ia, input logic [4:0] rs, input logic [4:0] rt);
    bit          w_win, exp_rdy, exp_we, exp_hit;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd, exp_pc;
    @(negedge clk);
    reset = rst; w_valid = wv; w_addr = wa; w_data = wd; w_pc = $urandom;
    m_valid = mv; m_addr = ma; m_data = md; m_pc = $urandom;
    iss_valid = iv; iss_addr = ia; q_rs = rs; q_rt = rt;
    #1;
    w_win   = wv && (wa != 0);
    exp_rdy = mv && !w_win;
    exp_we = 0; exp_a3 = 0; exp_wd = 0; exp_pc = 0;
    if (w_win) begin
      exp_we = 1; exp_a3 = wa; exp_wd = wd; exp_pc = w_pc;
    end else if (mv) begin
      exp_we = (ma != 0); exp_a3 = ma; exp_wd = md; exp_pc = m_pc;
    end
    exp_hit = (rs != 0 && model_pend[rs]) || (rt != 0 && model_pend[rt]);
    check("grf_we", 32'(grf_we), 32'(exp_we));
    check("grf_a3", 32'(grf_a3), 32'(exp_a3));
    check("grf_wd", grf_wd, exp_wd);
    check("grf_pc", grf_pc, exp_pc);
    check("m_ready", 32'(m_ready), 32'(exp_rdy));
    check("q_hit", 32'(q_hit), 32'(exp_hit));
    check("starve_stall", 32'(starve_stall), 32'(blocked_run >= LIMIT));
    $display("t=%0t rst=%0d w=%0d/%0d m=%0d/%0d iss=%0d/%0d q=%0d,%0d -> we=%0d a3=%0d wd=%h rdy=%0d hit=%0d stall=%0d",
             $time, rst, wv, wa, mv, ma, iv, ia, rs, rt, grf_we, grf_a3, grf_wd, m_ready, q_hit, starve_stall);
    @(posedge clk);
    if (rst) begin
      foreach (model_pend[i]) model_pend[i] = 0;
      blocked_run = 0;
    end else begin
      if (exp_rdy && ma != 0) model_pend[ma] = 0;
      if (iv && ia != 0) model_pend[ia] = 1;
      if (mv && !exp_rdy) blocked_run = (blocked_run < 15) ? blocked_run + 1 : 15;
      else blocked_run = 0;
    end
  endtask

  initial begin
    n_vec = 0; n_bad = 0; blocked_run = 0;
    foreach (model_pend[i]) model_pend[i] = 0;
    reset = 1; w_valid = 0; w_addr = 0; w_data = 0; w_pc = 0;
    m_valid = 0; m_addr = 0; m_data = 0; m_pc = 0;
    iss_valid = 0; iss_addr = 0; q_rs = 0; q_rt = 0;
    repeat (2) @(posedge clk);

    // Post-reset idle cycle, then W vs M collision and M follow-up.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    step(0, 1, 5, 32'h11, 1, 6, 32'h22, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 6, 32'h22, 0, 0, 0, 0);
    // Issue to r8, query, clear by handshake, query again.
    step(0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0);
    step(0, 0, 0, 0, 1, 8, 32'h88, 0, 0, 8, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0);
    // Set and clear of r9 in one cycle: set wins.
    step(0, 0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    // W to r0 does not block M; M to r0 is accepted without a write.
    step(0, 1, 0, 32'hDEAD, 1, 3, 32'h33, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h44, 0, 0, 0, 0);
    // Starvation under continuous W, then release.
    for (int i = 0; i < 6; i++) step(0, 1, 4, 32'(i), 1, 7, 32'h77, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Fill every register while starved, then reset.
    for (int a = 1; a < 32; a++) step(0, 1, 1, 32'(a), 1, 2, 32'h5, 1, 5'(a), 5'(a - 1), 0);
    step(0, 1, 1, 0, 1, 2, 32'h5, 0, 0, 31, 2);
    step(1, 1, 1, 0, 1, 2, 32'h5, 1, 12, 31, 2);
    for (int a = 0; a < 32; a++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a));

    // Random traffic, small address range so the scoreboard sees reuse.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 8), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/grf_wb_arbiter.md
GRF_WB_ARBITER -- requirements
Module: grf_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, giving the consecutive blocked-MDU cycles before a pipeline stall is forced (legal range 1..15).
REQ-002 SHALL have clk input, 1 bit, the clock.
REQ-003 SHALL have reset input, 1 bit; reset is synchronous, active-high.
REQ-004 SHALL have w_valid, w_addr, w_data, w_pc inputs (1, 5, 32, 32 bits): W-stage writeback request, never stallable.
REQ-005 SHALL have m_valid input 1, m_addr input 5, m_data input 32, m_pc input 32, and m_ready output 1: the MDU writeback valid/ready port.
REQ-006 SHALL have iss_valid input 1 and iss_addr input 5: an MDU op writing iss_addr is issued this cycle.
REQ-007 SHALL have q_rs input 5, q_rt input 5, and q_hit output 1: the D-stage scoreboard query.
REQ-008 SHALL have grf_we output 1, grf_a3 output 5, grf_wd output 32, grf_pc output 32: the single GRF write port.
REQ-009 SHALL have starve_stall output 1: a request that upstream inject a bubble into W.

Function
REQ-010 SHALL treat a W request as effective only when w_valid=1 and w_addr!=0; same for M with m_addr.
REQ-011 SHALL drive grf_* combinationally, zero latency: effective W gives we=1 with W fields; else m_valid gives we=(m_addr!=0) with M fields; else we=0 and a3/wd/pc=0.
REQ-012 SHALL assert m_ready=1 exactly when m_valid=1 and no effective W request; handshake = m_valid&m_ready.
REQ-013 SHALL accept an M handshake with m_addr=0 and write nothing (grf_we=0).
REQ-014 SHALL keep pending[31:0], with bit 0 hardwired 0.
REQ-015 SHALL set pending[iss_addr] at the clock edge when iss_valid=1 and iss_addr!=0.
REQ-016 SHALL clear pending[m_addr] at the clock edge on an M handshake.
REQ-017 SHALL let set win when set and clear hit the same address in one cycle.
REQ-018 SHALL drive q_hit = pending[q_rs] | pending[q_rt] from registered state only; an address of 0 contributes 0, and same-cycle clears are not bypassed.
REQ-019 SHALL implement FSM IDLE, WAIT, STARVE with a 4-bit counter cnt.
REQ-020 IDLE: on m_valid&!m_ready go to WAIT with cnt=1; else stay.
REQ-021 WAIT: on handshake or !m_valid go to IDLE with cnt=0; else increment cnt, and move to STARVE when cnt+1==STARVE_LIMIT.
REQ-022 STARVE: starve_stall=1; on handshake or !m_valid go to IDLE with cnt=0; else hold.
REQ-023 SHALL drive starve_stall=0 in IDLE and WAIT; it is a Moore output.
REQ-024 SHALL keep cnt saturating, never wrapping.

Reset
REQ-025 SHALL, on reset, clear pending to 0, set state to IDLE and cnt to 0, and drive starve_stall=0 and q_hit=0.
REQ-026 SHALL give reset priority over iss/handshake updates in the same cycle; an MDU transfer mid-reset is discarded.
REQ-027 SHALL keep grf_* and m_ready combinational during reset; the GRF ignores writes under its own reset.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, WAIT, STARVE) and REG_ZERO=5'd0 in the shared pipeline package.
REQ-029 SHALL use one natural sub-module, wb_scoreboard, holding pending, set/clear, and query.
REQ-030 SHALL need no other sub-modules; the arbiter mux and FSM live at top level.

Verification
REQ-031 Bench: W(addr 5, 0x11) and M(addr 6, 0x22) in the same cycle -> grf_we=1, a3=5, wd=0x11, m_ready=0; next cycle with w_valid=0 -> a3=6, wd=0x22, m_ready=1.
REQ-032 Bench: iss_valid addr 8 -> next cycle q_rs=8 gives q_hit=1; M handshake addr 8 -> q_hit=0 the cycle after.
REQ-033 Bench: iss addr 9 and M handshake addr 9 in the same cycle -> pending[9] remains 1.
REQ-034 Bench: STARVE_LIMIT=4 with m_valid held under continuous W -> starve_stall=1 from cycle 4; w_valid drops -> handshake, then IDLE and stall=0 next cycle.
REQ-035 Bench: w_addr=0 with m_valid addr 3 -> M is granted and grf_a3=3; M with addr 0 -> m_ready=1 and grf_we=0.
REQ-036 Bench: reset asserted with pending=0xFFFFFFFE while in STARVE -> next cycle pending=0, IDLE, starve_stall=0.
